// File: rtl/dma_pkg.sv
// Shared constants for the multi-channel DMA: FSM encoding, CTRL bit positions
// and per-channel register offsets within a channel's 4-word config window.
package dma_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_REQ   = 3'd1;
    localparam state_t ST_READ  = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_REL   = 3'd4;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_SRC_INC = 1;
    localparam int unsigned CTRL_DST_INC = 2;
    localparam int unsigned CTRL_HW_TRIG = 3;
    localparam int unsigned CTRL_ABORT   = 4;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin channel picker. The search starts just after the channel that
// was last granted, so every requesting channel is reached within NUM_CH picks.
module dma_rr_arbiter #(
    parameter int NUM_CH = 2,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [IDX_W-1:0]  pick,
    output logic              pick_valid
);

    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] idx;

    // Walk the channels cyclically after 'last'; the first requester wins.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = last;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(NUM_CH - 1)) begin
                idx = '0;
            end else begin
                idx = idx + IDX_W'(1);
            end
            if (!pick_valid && req[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    // Pointer resets to the highest channel so channel 0 is searched first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last <= IDX_W'(NUM_CH - 1);
        end else if (advance) begin
            last <= pick;
        end
    end

endmodule

// File: rtl/dma_multi_channel.sv
// Multi-channel DMA engine: CPU-programmed channel registers, round-robin
// service with bounded bursts, and a REQ/READ/WRITE/REL bus tenure FSM.
module dma_multi_channel
    import dma_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter int          NUM_CH   = 2,
    parameter int          LEN_W    = 8,
    parameter int          BURST    = 4,
    parameter int unsigned CFG_BASE = 5000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cfg_wr,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic [NUM_CH-1:0] dma_req,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              ADE,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              Read,
    output logic              Write,
    output logic [NUM_CH-1:0] ch_busy,
    output logic [NUM_CH-1:0] ch_done
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BC_W = $clog2(BURST + 1);

    logic [ADDR_W-1:0] src [NUM_CH];
    logic [ADDR_W-1:0] dst [NUM_CH];
    logic [LEN_W-1:0]  len [NUM_CH];
    logic [NUM_CH-1:0] src_inc, dst_inc, hw_trig, busy, abort_pend, done_q, eligible;

    state_t            state;
    logic [CH_W-1:0]   cur;
    logic [BC_W-1:0]   burst_cnt;
    logic [DATA_W-1:0] rbuf;

    logic [ADDR_W-1:0] cfg_off;
    logic              cfg_hit;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_k;
    logic [CH_W-1:0]   pick;
    logic              pick_valid;
    logic              advance;
    logic              in_tenure;
    logic [LEN_W-1:0]  len_next;
    logic [BC_W-1:0]   bc_next;

    // Out-of-range addresses (including those below the base) wrap to a large offset.
    assign cfg_off   = cfg_addr - ADDR_W'(CFG_BASE);
    assign cfg_hit   = cfg_wr && (cfg_off < ADDR_W'(4 * NUM_CH));
    assign cfg_ch    = cfg_off[CH_W+1:2];
    assign cfg_k     = cfg_off[1:0];
    assign in_tenure = (state == ST_REQ) || (state == ST_READ) || (state == ST_WRITE);
    assign advance   = (state == ST_IDLE) && pick_valid;
    assign len_next  = len[cur] - LEN_W'(1);
    assign bc_next   = burst_cnt + BC_W'(1);
    assign ch_busy   = busy;
    assign ch_done   = done_q;

    // A channel competes for the bus when busy, not aborting and (if hw-triggered) requested.
    always_comb begin
        eligible = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            eligible[c] = busy[c] && !abort_pend[c] && (!hw_trig[c] || dma_req[c]);
        end
    end

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .CLK        (CLK),
        .RST        (RST),
        .req        (eligible),
        .advance    (advance),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    // Bus-side outputs decode directly from the FSM state.
    always_comb begin
        bus_req = 1'b0;
        ADE     = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        case (state)
            ST_REQ: bus_req = 1'b1;
            ST_READ: begin
                bus_req = 1'b1;
                ADE     = 1'b1;
                Read    = 1'b1;
                m_addr  = src[cur];
            end
            ST_WRITE: begin
                bus_req = 1'b1;
                ADE     = 1'b1;
                Write   = 1'b1;
                m_addr  = dst[cur];
                m_wdata = rbuf;
            end
            default: ;
        endcase
    end

    // Channel register file, abort handling and the bus tenure FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            cur        <= '0;
            burst_cnt  <= '0;
            rbuf       <= '0;
            done_q     <= '0;
            src_inc    <= '0;
            dst_inc    <= '0;
            hw_trig    <= '0;
            busy       <= '0;
            abort_pend <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                src[c] <= '0;
                dst[c] <= '0;
                len[c] <= '0;
            end
        end else begin
            done_q <= '0;

            // A busy channel only listens to abort; its transfer state stays frozen.
            if (cfg_hit) begin
                if (busy[cfg_ch]) begin
                    if (cfg_k == REG_CTRL && cfg_wdata[CTRL_ABORT]) begin
                        abort_pend[cfg_ch] <= 1'b1;
                    end
                end else begin
                    case (cfg_k)
                        REG_SRC: src[cfg_ch] <= ADDR_W'(cfg_wdata);
                        REG_DST: dst[cfg_ch] <= ADDR_W'(cfg_wdata);
                        REG_LEN: len[cfg_ch] <= LEN_W'(cfg_wdata);
                        default: begin
                            src_inc[cfg_ch] <= cfg_wdata[CTRL_SRC_INC];
                            dst_inc[cfg_ch] <= cfg_wdata[CTRL_DST_INC];
                            hw_trig[cfg_ch] <= cfg_wdata[CTRL_HW_TRIG];
                            if (cfg_wdata[CTRL_START]) begin
                                if (len[cfg_ch] == '0) begin
                                    done_q[cfg_ch] <= 1'b1;
                                end else begin
                                    busy[cfg_ch] <= 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end

            // Channels not mid-word can drop out at once; the served one waits for WRITE.
            for (int c = 0; c < NUM_CH; c++) begin
                if (abort_pend[c] && !(in_tenure && cur == CH_W'(c))) begin
                    busy[c]       <= 1'b0;
                    abort_pend[c] <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        cur   <= pick;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    rbuf  <= m_rdata;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    src[cur]  <= src[cur] + ADDR_W'(src_inc[cur]);
                    dst[cur]  <= dst[cur] + ADDR_W'(dst_inc[cur]);
                    len[cur]  <= len_next;
                    burst_cnt <= bc_next;
                    if (len_next == '0) begin
                        done_q[cur]     <= 1'b1;
                        busy[cur]       <= 1'b0;
                        abort_pend[cur] <= 1'b0;
                        state           <= ST_REL;
                    end else if (abort_pend[cur]) begin
                        busy[cur]       <= 1'b0;
                        abort_pend[cur] <= 1'b0;
                        state           <= ST_REL;
                    end else if (bc_next == BC_W'(BURST) || (hw_trig[cur] && !dma_req[cur])) begin
                        state <= ST_REL;
                    end else begin
                        state <= ST_READ;
                    end
                end
                ST_REL: begin
                    burst_cnt <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_multi_channel.sv
// Scoreboard bench: stimulus pushes the expected reads, writes and done pulses
// computed from a tenure-level reference model; a negedge monitor pops and compares.
module tb_dma_multi_channel;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NUM_CH   = 2;
    localparam int LEN_W    = 8;
    localparam int BURST    = 4;
    localparam int CFG_BASE = 5000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic              cfg_wr;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic [NUM_CH-1:0] dma_req;
    logic              bus_req;
    logic              bus_gnt;
    logic              ADE;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              Read;
    logic              Write;
    logic [NUM_CH-1:0] ch_busy;
    logic [NUM_CH-1:0] ch_done;

    always #5 CLK = ~CLK;

    dma_multi_channel #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_CH   (NUM_CH),
        .LEN_W    (LEN_W),
        .BURST    (BURST),
        .CFG_BASE (CFG_BASE)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .dma_req   (dma_req),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .ADE       (ADE),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .Read      (Read),
        .Write     (Write),
        .ch_busy   (ch_busy),
        .ch_done   (ch_done)
    );

    // Slave memory: every address returns a fixed pseudo-random word.
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign m_rdata = rd_val(m_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_line(input string name, input logic [63:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, nothing was expected", name, got);
    endtask

    logic [31:0] exp_rd [$];
    wr_t         exp_wr [$];
    int          exp_done [$];

    // Channel configuration used by both the stimulus and the reference model.
    logic [31:0] c_src [2];
    logic [31:0] c_dst [2];
    int          c_len [2];
    bit          c_si [2];
    bit          c_di [2];
    bit          c_hw [2];
    bit          c_en [2];

    // Reference: a start with LEN=0 completes immediately; the first started busy
    // channel takes the first tenure; after that tenures rotate over channels with
    // words left, each moving at most BURST words.
    task automatic push_model();
        int rem [2];
        int idx [2];
        int cur;
        int nxt;
        int n;
        logic [31:0] a;
        wr_t w;
        for (int c = 0; c < 2; c++) begin
            rem[c] = c_en[c] ? c_len[c] : 0;
            idx[c] = 0;
            if (c_en[c] && c_len[c] == 0) exp_done.push_back(c);
        end
        cur = (rem[0] > 0) ? 0 : ((rem[1] > 0) ? 1 : -1);
        while (cur >= 0) begin
            n = (rem[cur] < BURST) ? rem[cur] : BURST;
            for (int k = 0; k < n; k++) begin
                a = c_src[cur] + (c_si[cur] ? 32'(idx[cur]) : 32'd0);
                exp_rd.push_back(a);
                w.addr = c_dst[cur] + (c_di[cur] ? 32'(idx[cur]) : 32'd0);
                w.data = rd_val(a);
                exp_wr.push_back(w);
                idx[cur]++;
            end
            rem[cur] -= n;
            if (rem[cur] == 0) exp_done.push_back(cur);
            nxt = -1;
            for (int k = 1; k <= 2; k++) begin
                if (nxt < 0 && rem[(cur + k) % 2] > 0) nxt = (cur + k) % 2;
            end
            cur = nxt;
        end
    endtask

    // Monitor: compare every bus strobe and done pulse against the scoreboard.
    int   cyc = 0;
    int   n_wr = 0;
    int   n_rw = 0;
    int   first_rw = -1;
    int   last_rw = -1;
    logic [31:0] m_ea;
    wr_t  m_ew;
    int   m_ed;

    always @(negedge CLK) begin
        cyc++;
        if (!RST) begin
            if (Read || Write) begin
                n_rw++;
                if (first_rw < 0) first_rw = cyc;
                last_rw = cyc;
                chk("rd_wr_exclusive", 64'(Read & Write), 64'd0);
                chk("ade_during_strobe", 64'(ADE), 64'd1);
            end
            if (Read) begin
                if (exp_rd.size() == 0) begin
                    fail_line("unexpected_read", 64'(m_addr));
                end else begin
                    m_ea = exp_rd.pop_front();
                    chk("read_addr", 64'(m_addr), 64'(m_ea));
                end
            end
            if (Write) begin
                n_wr++;
                if (exp_wr.size() == 0) begin
                    fail_line("unexpected_write", 64'(m_addr));
                end else begin
                    m_ew = exp_wr.pop_front();
                    chk("write_addr", 64'(m_addr), 64'(m_ew.addr));
                    chk("write_data", 64'(m_wdata), 64'(m_ew.data));
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_done[c]) begin
                    if (exp_done.size() == 0) begin
                        fail_line("unexpected_done", 64'(c));
                    end else begin
                        m_ed = exp_done.pop_front();
                        chk("done_channel", 64'(c), 64'(m_ed));
                    end
                end
            end
        end
    end

    // CPU side of the arbitration: grant after a random delay, or tie high.
    bit gnt_tied = 1'b0;
    int gnt_wait = 0;

    initial begin
        bus_gnt = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (gnt_tied) begin
                bus_gnt = 1'b1;
            end else if (!bus_req) begin
                bus_gnt  = 1'b0;
                gnt_wait = $urandom_range(0, 3);
            end else if (gnt_wait == 0) begin
                bus_gnt = 1'b1;
            end else begin
                gnt_wait--;
            end
        end
    end

    task automatic cfg_write(input int ch, input int k, input logic [31:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = 32'(CFG_BASE + 4 * ch + k);
        cfg_wdata = d;
        @(posedge CLK);
        #1;
        cfg_wr    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
    endtask

    // Program enabled channels, load the model, then start ch0 before ch1.
    task automatic run_set();
        logic [31:0] ctrl;
        for (int c = 0; c < 2; c++) begin
            if (c_en[c]) begin
                cfg_write(c, 0, c_src[c]);
                cfg_write(c, 1, c_dst[c]);
                cfg_write(c, 2, 32'(c_len[c]));
            end
        end
        push_model();
        for (int c = 0; c < 2; c++) begin
            if (c_en[c]) begin
                ctrl = 32'h1 | (32'(c_si[c]) << 1) | (32'(c_di[c]) << 2) | (32'(c_hw[c]) << 3);
                cfg_write(c, 3, ctrl);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(posedge CLK);
            #1;
            if (exp_rd.size() == 0 && exp_wr.size() == 0 && exp_done.size() == 0 &&
                ch_busy == '0 && !bus_req) done = 1'b1;
        end
        if (!done) fail_line({name, "_timeout"}, 64'(exp_wr.size()));
        chk({name, "_drained"}, 64'(exp_rd.size() + exp_wr.size() + exp_done.size()), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
        chk({name, "_ade_low"}, 64'(ADE), 64'd0);
    endtask

    task automatic flush();
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
    endtask

    int w0;
    bit hit;

    initial begin
        RST       = 1'b1;
        cfg_wr    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        dma_req   = '0;
        for (int c = 0; c < 2; c++) begin
            c_src[c] = '0; c_dst[c] = '0; c_len[c] = 0;
            c_si[c] = 1'b0; c_di[c] = 1'b0; c_hw[c] = 1'b0; c_en[c] = 1'b0;
        end
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 64'({bus_req, ADE, Read, Write, ch_busy, ch_done}), 64'd0);
        chk("reset_addr", 64'(m_addr), 64'd0);
        RST = 1'b0;

        // Single copy with grant tied high: back-to-back read/write pairs.
        gnt_tied = 1'b1;
        c_en[0] = 1'b1; c_src[0] = 32'd10; c_dst[0] = 32'd20; c_len[0] = 3;
        c_si[0] = 1'b1; c_di[0] = 1'b1;
        n_rw = 0; first_rw = -1;
        run_set();
        wait_idle("copy");
        chk("copy_strobes", 64'(n_rw), 64'd6);
        chk("copy_span", 64'(last_rw - first_rw), 64'd5);
        gnt_tied = 1'b0;

        // Fixed-address IO drain on ch1.
        c_en[0] = 1'b0; c_en[1] = 1'b1;
        c_src[1] = 32'd1001; c_dst[1] = 32'd100; c_len[1] = 2; c_si[1] = 1'b0; c_di[1] = 1'b1;
        run_set();
        wait_idle("io_drain");

        // Two channels sharing the bus in bursts.
        c_en[0] = 1'b1; c_en[1] = 1'b1;
        c_src[0] = 32'd400; c_dst[0] = 32'd500; c_len[0] = 6; c_si[0] = 1'b1; c_di[0] = 1'b1;
        c_src[1] = 32'd600; c_dst[1] = 32'd700; c_len[1] = 6; c_si[1] = 1'b1; c_di[1] = 1'b1;
        run_set();
        wait_idle("round_robin");

        // Hardware trigger: one word per single-cycle request pulse.
        c_en[1] = 1'b0;
        c_src[0] = 32'd200; c_dst[0] = 32'd300; c_len[0] = 3; c_hw[0] = 1'b1;
        w0 = n_wr;
        run_set();
        for (int p = 0; p < 3; p++) begin
            repeat (6) @(posedge CLK);
            #1;
            chk("hw_words_before", 64'(n_wr - w0), 64'(p));
            chk("hw_busy_held", 64'(ch_busy[0]), 64'd1);
            dma_req = 2'b01;
            @(posedge CLK);
            #1;
            dma_req = 2'b00;
            repeat (12) @(posedge CLK);
            #1;
            chk("hw_words_after", 64'(n_wr - w0), 64'(p + 1));
        end
        chk("hw_busy_cleared", 64'(ch_busy[0]), 64'd0);
        wait_idle("hw_trig");
        c_hw[0] = 1'b0;

        // LEN=0 start: done next cycle, never busy, no bus request.
        c_len[0] = 0;
        run_set();
        chk("len0_done", 64'(ch_done[0]), 64'd1);
        chk("len0_busy", 64'(ch_busy[0]), 64'd0);
        chk("len0_bus_req", 64'(bus_req), 64'd0);
        wait_idle("len0");

        // Abort: no-op on an idle channel, then mid-transfer on ch0.
        cfg_write(1, 3, 32'h10);
        chk("abort_idle_busy", 64'(ch_busy), 64'd0);
        c_src[0] = 32'd800; c_dst[0] = 32'd900; c_len[0] = 5;
        w0 = n_wr;
        run_set();
        exp_done.delete();
        hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(posedge CLK);
            #1;
            if (n_wr - w0 >= 1) hit = 1'b1;
        end
        if (!hit) fail_line("abort_first_word_timeout", 64'(n_wr - w0));
        cfg_write(0, 3, 32'h10);
        repeat (20) @(posedge CLK);
        #1;
        chk("abort_words", 64'((n_wr - w0 >= 1) && (n_wr - w0 <= 2)), 64'd1);
        chk("abort_busy", 64'(ch_busy[0]), 64'd0);
        flush();
        wait_idle("abort");

        // Reset during a WRITE cycle, then a normal transfer.
        c_src[0] = 32'd1200; c_dst[0] = 32'd1300; c_len[0] = 4;
        run_set();
        hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge CLK);
            if (Write) hit = 1'b1;
        end
        if (!hit) fail_line("reset_write_timeout", 64'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("rst_mid_bus", 64'({bus_req, ADE, Read, Write}), 64'd0);
        chk("rst_mid_busy", 64'(ch_busy), 64'd0);
        flush();
        c_len[0] = 3;
        run_set();
        wait_idle("after_reset");

        // Randomized channel pairs, including address wrap.
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 2; c++) begin
                c_src[c] = (r == 3) ? 32'hFFFF_FFFE : $urandom;
                c_dst[c] = $urandom;
                c_len[c] = $urandom_range(0, 9);
                c_si[c]  = 1'($urandom_range(0, 1));
                c_di[c]  = 1'($urandom_range(0, 1));
                c_en[c]  = 1'($urandom_range(0, 1));
            end
            if (!c_en[0] && !c_en[1]) c_en[r % 2] = 1'b1;
            run_set();
            wait_idle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
